ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the RAM word-address width.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive grants to one master while the other master waits (legal range 1..15).
REQ-003 The block SHALL have the following ports:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  master request; held until granted
- m0_addr / m1_addr  in  32  byte address
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wdata / m1_wdata  in  32  write data
- m0_gnt / m1_gnt  out  1  access accepted this cycle
- m0_rdata / m1_rdata  out  32  read data (copy of ram_rdata)
- m0_rvalid / m1_rvalid  out  1  read data valid for that master
- ram_addr  out  ADDR_WIDTH  word address to the RAM
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- ram_rdata_valid  in  1  RAM read-data valid, 1 cycle after the address

Function
REQ-004 A transfer SHALL occur in any cycle where mX_req=1 and mX_gnt=1; masters SHALL hold req, addr, we and wdata stable until then.
REQ-005 mX_gnt SHALL be combinational from req inputs and registered arbiter state; at most one gnt SHALL be high per cycle.
REQ-006 The arbiter SHALL keep registered state: owner {IDLE, M0, M1}, last_owner {M0, M1}, burst_cnt (4 bits), pend_rd (1), pend_id (1).
REQ-007 When only one master requests, it SHALL be granted.
REQ-008 When both request and owner is IDLE, the master not equal to last_owner SHALL be granted.
REQ-009 When both request and owner=Mx, Mx SHALL keep the grant while burst_cnt < MAX_BURST; otherwise the other master SHALL be granted.
REQ-010 On each transfer: if the granted master equals owner, burst_cnt SHALL increment, saturating at MAX_BURST; otherwise burst_cnt SHALL load 1. owner and last_owner SHALL both load the granted master.
REQ-011 In a cycle with no request, owner SHALL become IDLE and burst_cnt SHALL become 0; last_owner SHALL be retained.
REQ-012 ram_addr SHALL be addr[ADDR_WIDTH+1:2] of the granted master, or of m0 when no grant; address bits [1:0] and bits above ADDR_WIDTH+1 SHALL be ignored.
REQ-013 ram_we SHALL equal the granted master's we, and SHALL be 0 when there is no grant; ram_wdata SHALL be the granted master's wdata.
REQ-014 A granted read SHALL set pend_rd=1 and pend_id to the master index for the next cycle; any other cycle SHALL clear pend_rd.
REQ-015 mX_rvalid SHALL equal ram_rdata_valid AND pend_rd AND (pend_id==X); read latency SHALL be exactly 1 cycle after gnt.
REQ-016 ram_rdata_valid arriving with pend_rd=0 SHALL be ignored.
REQ-017 Writes SHALL complete in the gnt cycle, with no rvalid.
REQ-018 Back-to-back transfers SHALL be supported: one transfer per cycle, and a read's rvalid MAY coincide with the next gnt.
REQ-019 mX_rdata SHALL be driven with ram_rdata at all times; it SHALL be meaningful only when mX_rvalid=1.

Reset
REQ-020 While reset=1, owner SHALL be IDLE, last_owner SHALL be M1 (so m0 wins the first tie), burst_cnt and pend_rd SHALL be 0, and every gnt, rvalid and ram_we SHALL be 0.
REQ-021 Reset asserted mid-burst or with a read pending SHALL drop the pending read: no rvalid SHALL be produced for it after reset release.
REQ-022 After reset release, arbitration SHALL resume on the first clk edge with no extra wait cycles.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Single read: m0 reads addr 0x10 (word 4, RAM holds 0xDEADBEEF) -> m0_gnt in cycle N, m0_rvalid=1 with rdata 0xDEADBEEF at N+1, m1_rvalid stays 0.
- First tie: both request right after reset -> m0 is granted first.
- Burst limit: MAX_BURST=4, m0 and m1 request continuously -> grants go m0 x4, m1 x4, m0 x4; no gnt gap.
- Idle then tie: last grant was m0, one idle cycle, then both request -> m1 is granted.
- Interleaved routing: m0 write 0x55 to 0x20 at N, m1 read 0x20 at N+1 -> ram_we=1 only at N, m1_rvalid at N+2 with 0x55, m0_rvalid never high.
- Reset mid-read: m1 read granted at N, reset pulsed between N and N+1 -> no m1_rvalid; after release, both gnt are 0 until the next req.

Source files
------------

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Two-master arbiter in front of a single-port word-addressed RAM with a
//   fixed one-cycle read latency. Ties are broken round-robin from idle, and
//   a master holding the RAM keeps it for up to MAX_BURST consecutive grants
//   while the other master waits.
//
// Ports
//   clk, reset               : clock, asynchronous active-high reset
//   m0_* / m1_*              : master request channels (req/addr/we/wdata in,
//                              gnt/rdata/rvalid out); addr is a byte address
//   ram_addr/ram_we/ram_wdata: RAM command, driven by the granted master
//   ram_rdata/ram_rdata_valid: RAM read return, one cycle after the address
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [31:0]           m0_addr,
    input  logic                  m0_we,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [31:0]           m1_addr,
    input  logic                  m1_we,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_rdata_valid
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_e      owner_q, owner_d;
    logic        last_owner_q, last_owner_d;   // 0 = M0, 1 = M1
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        pend_rd_q, pend_rd_d;
    logic        pend_id_q, pend_id_d;

    logic        gnt0, gnt1;
    logic        xfer;
    logic        gnt_id;
    logic        sel_we;
    logic [31:0] sel_addr;

    // Byte-offset bits and bits above the RAM window are intentionally unused.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m0_addr[31:ADDR_WIDTH+2],
                                m1_addr[1:0], m1_addr[31:ADDR_WIDTH+2]};

    // Grant decision: purely combinational from requests and registered state,
    // so a master sees its grant in the same cycle it requests.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the if/case leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                unique case (owner_q)
                    OWN_M0: begin
                        gnt0 = (burst_cnt_q < BURST_MAX);
                        gnt1 = !gnt0;
                    end
                    OWN_M1: begin
                        gnt1 = (burst_cnt_q < BURST_MAX);
                        gnt0 = !gnt1;
                    end
                    default: begin
                        // From idle, the master that did not go last wins.
                        gnt0 = last_owner_q;
                        gnt1 = !last_owner_q;
                    end
                endcase
            end
        end
    end

    assign xfer     = gnt0 | gnt1;
    assign gnt_id   = gnt1;
    assign sel_addr = gnt1 ? m1_addr : m0_addr;
    assign sel_we   = gnt1 ? m1_we   : m0_we;

    // Next-state for ownership, burst counting and the pending-read tracker.
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        pend_rd_d    = 1'b0;
        pend_id_d    = pend_id_q;
        if (xfer) begin
            if ((gnt_id && owner_q == OWN_M1) || (!gnt_id && owner_q == OWN_M0)) begin
                burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q
                                                         : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd1;
            end
            owner_d      = gnt_id ? OWN_M1 : OWN_M0;
            last_owner_d = gnt_id;
            pend_rd_d    = !sel_we;
            pend_id_d    = gnt_id;
        end else begin
            // A grant always follows any request, so no transfer means no request.
            owner_d     = OWN_IDLE;
            burst_cnt_d = 4'd0;
        end
    end

    // Reset clears pend_rd asynchronously, so a read in flight across reset
    // can never produce rvalid afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            pend_rd_q    <= 1'b0;
            pend_id_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            pend_rd_q    <= pend_rd_d;
            pend_id_q    <= pend_id_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign ram_addr  = sel_addr[ADDR_WIDTH+1:2];
    assign ram_we    = xfer & sel_we;
    assign ram_wdata = gnt1 ? m1_wdata : m0_wdata;

    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;
    assign m0_rvalid = ram_rdata_valid & pend_rd_q & !pend_id_q;
    assign m1_rvalid = ram_rdata_valid & pend_rd_q &  pend_id_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a small behavioural RAM (one-cycle
//   read latency). Inputs change 1 ns after a rising edge; outputs are
//   checked 1 ns after that, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          ram_rdata_valid;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: word 4 preloaded with 0xDEADBEEF while reset is held.
    logic        preload;
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_rdata       <= mem[ram_addr];
        ram_rdata_valid <= (m0_gnt | m1_gnt) & ~ram_we;
        if (preload)     mem[4]        <= 32'hDEAD_BEEF;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        // Both request with writes during reset: nothing may be granted.
        drive(1, 1, 32'h400, 32'h1, 1, 1, 32'h804, 32'h2);
        #1;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        next_cycle();
        reset   = 1'b0;
        preload = 1'b0;

        // First tie after reset, then burst limit: m0 x4, m1 x4, m0 x4.
        for (int i = 0; i < 12; i++) begin
            logic exp1;
            exp1 = (i >= 4 && i < 8);
            #1;
            check($sformatf("burst%0d_m0_gnt", i), m0_gnt, !exp1);
            check($sformatf("burst%0d_m1_gnt", i), m1_gnt, exp1);
            check($sformatf("burst%0d_ram_addr", i), ram_addr, exp1 ? 32'h201 : 32'h100);
            check($sformatf("burst%0d_ram_we", i), ram_we, 1);
            next_cycle();
        end

        // Idle then tie: last grant was m0, so m1 wins.
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("idle_m0_gnt", m0_gnt, 0);
        check("idle_m1_gnt", m1_gnt, 0);
        check("idle_ram_we", ram_we, 0);
        next_cycle();
        drive(1, 1, 32'h400, 32'h3, 1, 1, 32'h804, 32'h4);
        #1;
        check("tie_m1_gnt", m1_gnt, 1);
        check("tie_m0_gnt", m0_gnt, 0);
        check("tie_ram_wdata", ram_wdata, 32'h4);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        next_cycle();

        // Single read of 0x10, then back-to-back read with junk in ignored bits.
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("rd_m0_gnt", m0_gnt, 1);
        check("rd_ram_addr", ram_addr, 4);
        check("rd_ram_we", ram_we, 0);
        next_cycle();
        drive(1, 0, 32'hABCD_F013, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("rd_m0_rvalid", m0_rvalid, 1);
        check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_rvalid", m1_rvalid, 0);
        check("b2b_m0_gnt", m0_gnt, 1);
        check("b2b_ram_addr", ram_addr, 4);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("b2b_m0_rvalid", m0_rvalid, 1);
        check("b2b_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        next_cycle();
        check("rd_done_m0_rvalid", m0_rvalid, 0);

        // Interleaved routing: m0 writes 0x55 to 0x20, m1 reads it back.
        drive(1, 1, 32'h20, 32'h55, 0, 0, 32'h0, 32'h0);
        #1;
        check("il_w_m0_gnt", m0_gnt, 1);
        check("il_w_ram_we", ram_we, 1);
        check("il_w_ram_addr", ram_addr, 8);
        check("il_w_ram_wdata", ram_wdata, 32'h55);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        #1;
        check("il_r_m1_gnt", m1_gnt, 1);
        check("il_r_ram_we", ram_we, 0);
        check("il_r_m0_rvalid", m0_rvalid, 0);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("il_m1_rvalid", m1_rvalid, 1);
        check("il_m1_rdata", m1_rdata, 32'h55);
        check("il_m0_rvalid", m0_rvalid, 0);
        next_cycle();

        // Reset pulsed while an m1 read is in flight: its rvalid must vanish.
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
        #1;
        check("rr_m1_gnt", m1_gnt, 1);
        next_cycle();
        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("rr_ram_valid_seen", ram_rdata_valid, 1);
        check("rr_in_rst_m1_rvalid", m1_rvalid, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rr_post_m1_rvalid", m1_rvalid, 0);
        check("rr_post_m0_gnt", m0_gnt, 0);
        check("rr_post_m1_gnt", m1_gnt, 0);
        next_cycle();
        check("rr_idle_m0_gnt", m0_gnt, 0);
        check("rr_idle_m1_gnt", m1_gnt, 0);
        check("rr_idle_m1_rvalid", m1_rvalid, 0);
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("rr_resume_m0_gnt", m0_gnt, 1);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check("rr_resume_m0_rvalid", m0_rvalid, 1);
        check("rr_resume_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
